// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR pattern source and MISR response compactor for BIST
// of 18-input / 10-output combinational gate models.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for start; pattern = seed, signature/count cleared
//  RUN   | one pattern applied and one response absorbed per cycle
//  DONE  | run finished; signature and pass held until start or abort
module gate_bist_ctrl #(
    parameter int               PAT_W      = 18,
    parameter int               RSP_W      = 10,
    parameter int               N_PATTERNS = 256,
    parameter logic [PAT_W-1:0] SEED       = 18'h00001,
    parameter logic [15:0]      GOLDEN     = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [PAT_W-1:0] pattern,
    input  logic [RSP_W-1:0] response,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [PAT_W-1:0] SEED_EFF =
        (SEED == '0) ? {{(PAT_W-1){1'b0}}, 1'b1} : SEED;
    localparam logic [15:0] LAST = 16'(N_PATTERNS - 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [15:0]      sig_q, sig_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             pass_q, pass_d;

    logic [15:0]      sig_step;
    logic [PAT_W-1:0] pat_step;
    logic             fb;

    // State and datapath registers; async reset loads the idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= SEED_EFF;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, LFSR/MISR stepping and run bookkeeping; abort wins over start.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;

        fb       = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
        sig_step = {sig_q[14:0], fb} ^ 16'(response);
        pat_step = {pat_q[PAT_W-2:0], pat_q[PAT_W-1] ^ pat_q[10]};

        if (abort) begin
            state_d = IDLE;
            pat_d   = SEED_EFF;
            sig_d   = '0;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = RUN;
                        pat_d   = SEED_EFF;
                        sig_d   = '0;
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                    end
                end
                RUN: begin
                    sig_d = sig_step;
                    pat_d = pat_step;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        pass_d  = (sig_step == GOLDEN);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign pattern   = pat_q;
    assign signature = sig_q;
    assign pass      = pass_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: a driver issues runs and pushes the
// expected pattern/signature trace, a negedge monitor pops and compares.
module tb_gate_bist_ctrl;

    localparam int N = 20;
    localparam logic [17:0] SEED_TB = 18'h00001;

    function automatic logic [15:0] ones_golden(int n);
        int s;
        int f;
        s = 0;
        for (int i = 0; i < n; i++) begin
            f = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
            s = ((((s << 1) & 'hffff) | f) ^ 1);
        end
        return 16'(s);
    endfunction

    localparam logic [15:0] GOLDEN_TB = ones_golden(N);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [17:0] pattern;
    logic [9:0]  response;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int cur_mode;
    int cur_key;
    int n_checks = 0;
    int n_pass   = 0;

    int exp_pat[$];
    int exp_sig[$];
    int res_sig[$];
    int res_pass[$];

    gate_bist_ctrl #(
        .PAT_W(18), .RSP_W(10), .N_PATTERNS(N),
        .SEED(SEED_TB), .GOLDEN(GOLDEN_TB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .response(response), .busy(busy),
        .done(done), .pass(pass), .signature(signature)
    );

    always #5 clk = ~clk;

    // Gate model stand-in: tied 0, tied 1, or a keyed hash of the pattern.
    function automatic int gate_resp(int p, int mode, int key);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return ((p ^ (p >> 8)) ^ key) & 'h3ff;
    endfunction

    always_comb response = 10'(gate_resp(int'(pattern), cur_mode, cur_key));

    function automatic int lfsr_next(int p);
        return ((p << 1) & 'h3ffff) | (((p >> 17) ^ (p >> 10)) & 1);
    endfunction

    function automatic int misr_next(int s, int r);
        int f;
        f = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return (((s << 1) & 'hffff) | f) ^ r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_run();
        int p;
        int s;
        p = int'(SEED_TB);
        s = 0;
        for (int k = 0; k < N; k++) begin
            exp_pat.push_back(p);
            exp_sig.push_back(s);
            s = misr_next(s, gate_resp(p, cur_mode, cur_key));
            p = lfsr_next(p);
        end
        res_sig.push_back(s);
        res_pass.push_back(int'(s == int'(GOLDEN_TB)));
    endtask

    task automatic flush();
        exp_pat.delete();
        exp_sig.delete();
        res_sig.delete();
        res_pass.delete();
    endtask

    task automatic check_idle(string tag);
        check({tag, "_pattern"}, int'(pattern), int'(SEED_TB));
        check({tag, "_signature"}, int'(signature), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
    endtask

    // Monitor: per RUN cycle compare pattern and pre-absorb signature; on done
    // rising compare the final signature, pass and the run length.
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (pass && !done) check("pass_without_done", 1, 0);
            if (busy) begin
                if (exp_pat.size() == 0) begin
                    check("extra_busy_cycle", 1, 0);
                end else begin
                    check("run_pattern", int'(pattern), exp_pat.pop_front());
                    check("run_signature", int'(signature), exp_sig.pop_front());
                end
            end
            if (done && !prev_done) begin
                check("run_length_left", exp_pat.size(), 0);
                if (res_sig.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("final_signature", int'(signature), res_sig.pop_front());
                    check("final_pass", int'(pass), res_pass.pop_front());
                end
            end
            prev_done = done;
        end
    end

    // Entered and left at posedge+1. poke pulses start once mid-run.
    task automatic run_once(int mode, int key, bit poke);
        int poke_at;
        bit got;
        cur_mode = mode;
        cur_key  = key;
        start = 1'b1;
        push_run();
        @(posedge clk); #1 start = 1'b0;
        poke_at = poke ? int'($urandom_range(1, N - 2)) : -1;
        got = 1'b0;
        for (int j = 1; j <= N + 3 && !got; j++) begin
            if (j == poke_at) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            if (done) got = 1'b1;
        end
        check("done_timeout", int'(got), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_abort(string tag);
        abort = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1 abort = 1'b0;
        start = 1'b0;
        flush();
        @(negedge clk);
        check_idle(tag);
        repeat (3) @(posedge clk);
        #1 check_idle({tag, "_hold"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int m;
        int k;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cur_mode = 0;
        cur_key = 0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_idle("idle_no_start");

        run_once(0, 0, 1'b0);
        run_once(1, 0, 1'b0);
        run_once(1, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            m = int'($urandom_range(0, 2));
            k = int'($urandom_range(0, 1023));
            run_once(m, k, 1'($urandom_range(0, 1)));
            if (i % 3 == 0) run_once(m, k, 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            cur_mode = 2;
            cur_key = int'($urandom_range(0, 1023));
            start = 1'b1;
            push_run();
            @(posedge clk); #1 start = 1'b0;
            repeat ($urandom_range(1, N - 2)) @(posedge clk);
            #1 do_abort("abort_run");
        end

        run_once(1, 0, 1'b0);
        do_abort("abort_done");
        run_once(2, int'($urandom_range(0, 1023)), 1'b0);

        cur_mode = 2;
        cur_key = int'($urandom_range(0, 1023));
        start = 1'b1;
        push_run();
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        flush();
        #1 check_idle("async_rst");
        @(posedge clk); #1 check_idle("rst_held");
        rst = 1'b0;
        @(posedge clk); #1;
        run_once(2, int'($urandom_range(0, 1023)), 1'b0);
        run_once(1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
